// File: rtl/pipe_pkg.sv
// Shared encodings and constants for the pipeline front end.
package pipe_pkg;

  localparam logic [31:0] NOP             = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF  = 32'h0000_0008;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JR     = 2'b10;
  localparam logic [1:0] PCSRC_JUMP   = 2'b11;

  localparam logic [1:0] SELPC_NORMAL = 2'b00;
  localparam logic [1:0] SELPC_EPC    = 2'b01;

  typedef enum logic {
    FETCH = 1'b0,
    DROP  = 1'b1
  } if_state_t;

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pipe_npc_mux.sv
// Next-PC selection: normal flow target and exception/return target.
module pipe_npc_mux
  import pipe_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic [31:0] pc4,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic [1:0]  selpc,
  input  logic [31:0] epc,
  output logic [31:0] npc,
  output logic [31:0] exc_target,
  output logic        exc
);

  // Target selection; all candidates are forced to word alignment.
  always_comb begin
    npc = word_align(pc4);
    unique case (pcsrc)
      PCSRC_SEQ:    npc = word_align(pc4);
      PCSRC_BRANCH: npc = word_align(bpc);
      PCSRC_JR:     npc = word_align(rpc);
      PCSRC_JUMP:   npc = word_align(jpc);
      default:      npc = word_align(pc4);
    endcase

    exc        = (selpc != SELPC_NORMAL);
    exc_target = (selpc == SELPC_EPC) ? word_align(epc) : word_align(EXC_VECTOR);
  end

endmodule

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage: PC register, imem handshake, exception redirect.
//
// state | meaning
// ------+--------------------------------------------------------------
// FETCH | request at pc; completes when imem_ready, then pc advances
// DROP  | redirect pending while old fetch drains; data is discarded
module pipe_if_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wpcir,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic [1:0]  selpc,
  input  logic [31:0] epc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic [31:0] inst,
  output logic        if_busy
);

  if_state_t   state;
  logic [31:0] pend;
  logic [31:0] npc;
  logic [31:0] exc_target;
  logic        exc;

  assign pc4 = pc + 32'd4;

  pipe_npc_mux #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_npc_mux (
    .pc4        (pc4),
    .pcsrc      (pcsrc),
    .bpc        (bpc),
    .rpc        (rpc),
    .jpc        (jpc),
    .selpc      (selpc),
    .epc        (epc),
    .npc        (npc),
    .exc_target (exc_target),
    .exc        (exc)
  );

  // Fetch FSM with PC and pending-redirect registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      pend  <= 32'h0;
      state <= FETCH;
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_ready) begin
            if (exc)        pc <= exc_target;
            else if (wpcir) pc <= npc;
          end else if (exc) begin
            pend  <= exc_target;
            state <= DROP;
          end
        end
        DROP: begin
          // A redirect arriving on the drain cycle is newer than pend.
          if (exc) pend <= exc_target;
          if (imem_ready) begin
            pc    <= exc ? exc_target : pend;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Handshake and IF/ID outputs; address stays at pc until the request completes.
  always_comb begin
    imem_req  = !rst;
    imem_addr = pc;
    inst      = NOP;
    if_busy   = 1'b1;
    if (!rst) begin
      if (state == FETCH) begin
        if_busy = !imem_ready;
        if (imem_ready && !exc) inst = imem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_pipe_if_stage.sv
// Directed, table-driven bench for the instruction-fetch stage.
module tb_pipe_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        wpcir;
  logic [1:0]  pcsrc;
  logic [31:0] bpc, rpc, jpc;
  logic [1:0]  selpc;
  logic [31:0] epc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc, pc4, inst;
  logic        if_busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_if_stage dut (
    .clk        (clk),
    .rst        (rst),
    .wpcir      (wpcir),
    .pcsrc      (pcsrc),
    .bpc        (bpc),
    .rpc        (rpc),
    .jpc        (jpc),
    .selpc      (selpc),
    .epc        (epc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .pc         (pc),
    .pc4        (pc4),
    .inst       (inst),
    .if_busy    (if_busy)
  );

  typedef struct {
    logic        rst;
    logic        wpcir;
    logic [1:0]  pcsrc;
    logic [1:0]  selpc;
    logic [31:0] jpc;
    logic [31:0] epc;
    logic        ready;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_inst;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic w, input logic [1:0] ps, input logic [1:0] sp,
                     input logic [31:0] j, input logic [31:0] e, input logic rdy,
                     input logic [31:0] rd, input logic erq, input logic [31:0] ea,
                     input logic [31:0] ei, input logic eb);
    vec_t v;
    v.rst = r; v.wpcir = w; v.pcsrc = ps; v.selpc = sp; v.jpc = j; v.epc = e;
    v.ready = rdy; v.rdata = rd; v.e_req = erq; v.e_addr = ea; v.e_inst = ei; v.e_busy = eb;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; wpcir = v.wpcir; pcsrc = v.pcsrc; selpc = v.selpc;
    jpc = v.jpc; epc = v.epc; imem_ready = v.ready; imem_rdata = v.rdata;
  endtask

  task automatic check_row(input int i, input vec_t v);
    chk("imem_req", i, {31'b0, imem_req}, {31'b0, v.e_req});
    chk("imem_addr", i, imem_addr, v.e_addr);
    chk("pc", i, pc, v.e_addr);
    chk("pc4", i, pc4, v.e_addr + 32'd4);
    chk("inst", i, inst, v.e_inst);
    chk("if_busy", i, {31'b0, if_busy}, {31'b0, v.e_busy});
  endtask

  localparam logic [31:0] J0 = 32'h20;
  localparam logic [31:0] E0 = 32'h1003;

  initial begin
    int busy_cycles;
    bpc = 32'h40;
    rpc = 32'h203;
    //   rst wp ps     sp     jpc           epc      rdy rdata          req addr           inst           busy
    add(1, 1, 2'b00, 2'b00, J0,           E0,      1, 32'hAAAA_AAAA, 0, 32'h0,          32'h0,         1); // 0 reset
    add(0, 1, 2'b00, 2'b00, J0,           E0,      1, 32'h11,        1, 32'h0,          32'h11,        0); // 1
    add(0, 1, 2'b00, 2'b00, J0,           E0,      1, 32'h22,        1, 32'h4,          32'h22,        0); // 2
    add(0, 1, 2'b00, 2'b00, J0,           E0,      1, 32'h33,        1, 32'h8,          32'h33,        0); // 3
    add(0, 1, 2'b00, 2'b00, J0,           E0,      1, 32'h44,        1, 32'hC,          32'h44,        0); // 4
    add(0, 1, 2'b00, 2'b00, J0,           E0,      0, 32'hBAD0,      1, 32'h10,         32'h0,         1); // 5 wait
    add(0, 1, 2'b00, 2'b00, J0,           E0,      0, 32'hBAD1,      1, 32'h10,         32'h0,         1); // 6 wait
    add(0, 1, 2'b00, 2'b00, J0,           E0,      1, 32'h55,        1, 32'h10,         32'h55,        0); // 7
    add(0, 1, 2'b01, 2'b00, J0,           E0,      1, 32'h66,        1, 32'h14,         32'h66,        0); // 8 branch
    add(0, 0, 2'b01, 2'b00, J0,           E0,      1, 32'h77,        1, 32'h40,         32'h77,        0); // 9 hold
    add(0, 0, 2'b01, 2'b00, J0,           E0,      1, 32'h77,        1, 32'h40,         32'h77,        0); // 10 hold
    add(0, 1, 2'b10, 2'b00, J0,           E0,      1, 32'h78,        1, 32'h40,         32'h78,        0); // 11 jr
    add(0, 1, 2'b11, 2'b00, J0,           E0,      1, 32'h79,        1, 32'h200,        32'h79,        0); // 12 j
    add(0, 1, 2'b00, 2'b10, J0,           E0,      0, 32'hBAD2,      1, 32'h20,         32'h0,         1); // 13 exc->DROP
    add(0, 1, 2'b00, 2'b00, J0,           E0,      0, 32'hBAD3,      1, 32'h20,         32'h0,         1); // 14
    add(0, 1, 2'b00, 2'b00, J0,           E0,      0, 32'hBAD4,      1, 32'h20,         32'h0,         1); // 15
    add(0, 1, 2'b00, 2'b00, J0,           E0,      1, 32'hDEAD,      1, 32'h20,         32'h0,         1); // 16 drained
    add(0, 0, 2'b00, 2'b01, J0,           E0,      1, 32'h88,        1, 32'h8,          32'h0,         0); // 17 eret
    add(0, 1, 2'b00, 2'b00, J0,           E0,      1, 32'h99,        1, 32'h1000,       32'h99,        0); // 18
    add(0, 1, 2'b00, 2'b01, J0,           32'h2000,0, 32'hBAD5,      1, 32'h1004,       32'h0,         1); // 19 DROP pend=2000
    add(0, 1, 2'b00, 2'b11, J0,           E0,      0, 32'hBAD6,      1, 32'h1004,       32'h0,         1); // 20 newest wins
    add(0, 1, 2'b00, 2'b00, J0,           E0,      1, 32'hBAD7,      1, 32'h1004,       32'h0,         1); // 21 drained
    add(0, 1, 2'b00, 2'b00, J0,           E0,      1, 32'hAB,        1, 32'h8,          32'hAB,        0); // 22
    add(0, 1, 2'b00, 2'b10, J0,           E0,      0, 32'hBAD8,      1, 32'hC,          32'h0,         1); // 23 DROP
    add(1, 1, 2'b00, 2'b00, J0,           E0,      1, 32'hBAD9,      0, 32'hC,          32'h0,         1); // 24 reset mid-DROP
    add(0, 1, 2'b00, 2'b00, J0,           E0,      1, 32'hCD,        1, 32'h0,          32'hCD,        0); // 25
    add(0, 1, 2'b11, 2'b00, 32'hFFFF_FFFF,E0,      1, 32'hCE,        1, 32'h4,          32'hCE,        0); // 26
    add(0, 1, 2'b00, 2'b00, J0,           E0,      1, 32'hEE,        1, 32'hFFFF_FFFC,  32'hEE,        0); // 27 wrap
    add(0, 1, 2'b00, 2'b00, J0,           E0,      1, 32'hEF,        1, 32'h0,          32'hEF,        0); // 28

    // Initial reset so pc is defined before the table starts.
    rst = 1'b1; wpcir = 1'b1; pcsrc = 2'b00; selpc = 2'b00; jpc = J0; epc = E0;
    imem_ready = 1'b0; imem_rdata = 32'h0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check_row(i, vecs[i]);
    end

    // pc is now 4; hold ready low for 4 cycles and count the busy cycles.
    busy_cycles = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      rst = 1'b0; selpc = 2'b00; pcsrc = 2'b00; wpcir = 1'b1;
      imem_ready = 1'b0; imem_rdata = 32'hF00D;
      #1;
      if (if_busy) busy_cycles++;
      chk("stall_addr", 100 + c, imem_addr, 32'h4);
      chk("stall_inst", 100 + c, inst, 32'h0);
    end
    chk("stall_busy_count", 104, busy_cycles, 4);
    @(negedge clk);
    imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
    #1;
    chk("stall_done_busy", 105, {31'b0, if_busy}, 32'h0);
    chk("stall_done_inst", 105, inst, 32'h1234_5678);
    @(negedge clk);
    #1;
    chk("stall_next_addr", 106, imem_addr, 32'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
